// File: rtl/power_integrator.sv
// power_integrator
// Computes per-lane power |x|^2 of complex input bins, rounds away LSBs,
// clamps to the power word width and integrates over num_frames frames of
// DEPTH beats each in a read-modify-write accumulation buffer. The final
// frame's sums are presented three cycles after the corresponding input beat.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - one-cycle pulse, latches num_frames and arms integration
//   num_frames - frames to integrate (0 behaves as 1)
//   valid      - input beat qualifier, no backpressure
//   in_r, in_i - LANES signed real/imag samples, lane k = bin beat*LANES+k
//   out_valid  - integrated result beat valid
//   out_data   - LANES integrated power values
//   out_index  - beat index of out_data
//   busy       - high while running
//   done       - one-cycle pulse after the final output beat
//   sat        - sticky: power clamp or accumulator saturation occurred
//   err        - sticky: valid received while idle
module power_integrator #(
  parameter int LANES          = 4,
  parameter int IN_DATA_WIDTH  = 32,
  parameter int LSB_CUTOFF     = 10,
  parameter int MSB_CUTOFF     = 52,
  parameter int OUT_DATA_WIDTH = 53,
  parameter int DEPTH          = 2048,
  parameter int FRM_W          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [FRM_W-1:0]                  num_frames,
  input  logic                              valid,
  input  logic [LANES*IN_DATA_WIDTH-1:0]    in_r,
  input  logic [LANES*IN_DATA_WIDTH-1:0]    in_i,
  output logic                              out_valid,
  output logic [LANES*OUT_DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH)-1:0]          out_index,
  output logic                              busy,
  output logic                              done,
  output logic                              sat,
  output logic                              err
);

  localparam int PWR_W = MSB_CUTOFF - LSB_CUTOFF + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 2 * IN_DATA_WIDTH;
  localparam int DW    = LANES * OUT_DATA_WIDTH;
  localparam logic [PW:0]   RND_C     = (PW+1)'(1) << (LSB_CUTOFF - 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [AW-1:0]          beat_cnt;
  logic [FRM_W-1:0]       frame_cnt;
  logic [FRM_W-1:0]       nf_lat;
  logic                   feeding;

  logic                   s1_valid, s1_first, s1_final, s1_last;
  logic [LANES*PWR_W-1:0] s1_pwr;
  logic [AW-1:0]          s1_addr;
  logic                   s2_valid, s2_first, s2_final, s2_last;
  logic [LANES*PWR_W-1:0] s2_pwr;
  logic [AW-1:0]          s2_addr;
  logic [DW-1:0]          s2_rd;
  logic                   fin_out;

  logic [DW-1:0]          mem [DEPTH];

  logic                   accept, is_final;
  logic [LANES*PWR_W-1:0] pwr_c;
  logic                   clamp_c;
  logic [DW-1:0]          sum_c;
  logic                   acc_sat_c;

  // Feeding drops to 0 after the last input beat so that stray beats arriving
  // while the pipeline drains do not disturb the finished frame.
  assign accept   = (state == RUN) && feeding && valid;
  assign is_final = (frame_cnt == nf_lat - FRM_W'(1));
  assign busy     = (state == RUN);

  // Exact power per lane, rounded half-up by adding half an output LSB before
  // the shift; anything left above the power word after rounding is clamped.
  always_comb begin
    logic signed [IN_DATA_WIDTH-1:0] rv, iv;
    logic signed [PW-1:0]            rx, ix;
    logic [PW-1:0]                   rsq, isq;
    logic [PW:0]                     rnd;
    pwr_c   = '0;
    clamp_c = 1'b0;
    rv = '0; iv = '0; rx = '0; ix = '0; rsq = '0; isq = '0; rnd = '0;
    for (int k = 0; k < LANES; k++) begin
      rv  = in_r[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
      iv  = in_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
      rx  = PW'(rv);
      ix  = PW'(iv);
      rsq = rx * rx;
      isq = ix * ix;
      rnd = {1'b0, rsq} + {1'b0, isq} + RND_C;
      if ((rnd >> (LSB_CUTOFF + PWR_W)) != '0) begin
        pwr_c[k*PWR_W +: PWR_W] = '1;
        clamp_c = 1'b1;
      end else begin
        pwr_c[k*PWR_W +: PWR_W] = rnd[LSB_CUTOFF +: PWR_W];
      end
    end
  end

  // Frame 0 ignores the buffer contents, so stale data after reset never
  // leaks into a new integration and no clearing pass is needed.
  always_comb begin
    logic [OUT_DATA_WIDTH:0] t;
    sum_c     = '0;
    acc_sat_c = 1'b0;
    t         = '0;
    for (int k = 0; k < LANES; k++) begin
      t = (OUT_DATA_WIDTH+1)'(s2_pwr[k*PWR_W +: PWR_W]);
      if (!s2_first)
        t = t + {1'b0, s2_rd[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]};
      if (t[OUT_DATA_WIDTH]) begin
        sum_c[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = '1;
        acc_sat_c = 1'b1;
      end else begin
        sum_c[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = t[OUT_DATA_WIDTH-1:0];
      end
    end
  end

  // Accumulation buffer: read in stage 2, write back in stage 3. The same
  // address is revisited only a full frame later, so reads never race writes.
  always_ff @(posedge clk) begin
    if (s1_valid)
      s2_rd <= mem[s1_addr];
    if (s2_valid)
      mem[s2_addr] <= sum_c;
  end

  // Control FSM and pipeline. The machine stays in RUN until the final
  // output beat leaves stage 3; done follows one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      nf_lat    <= '0;
      feeding   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_final  <= 1'b0;
      s1_last   <= 1'b0;
      s1_pwr    <= '0;
      s1_addr   <= '0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_final  <= 1'b0;
      s2_last   <= 1'b0;
      s2_pwr    <= '0;
      s2_addr   <= '0;
      fin_out   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
      sat       <= 1'b0;
      err       <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_pwr   <= pwr_c;
      s1_addr  <= beat_cnt;
      s1_first <= (frame_cnt == '0);
      s1_final <= is_final;
      s1_last  <= is_final && (beat_cnt == LAST_BEAT);

      s2_valid <= s1_valid;
      s2_pwr   <= s1_pwr;
      s2_addr  <= s1_addr;
      s2_first <= s1_first;
      s2_final <= s1_final;
      s2_last  <= s1_last;

      out_valid <= s2_valid && s2_final;
      if (s2_valid && s2_final) begin
        out_data  <= sum_c;
        out_index <= s2_addr;
      end
      fin_out <= s2_valid && s2_last;
      done    <= fin_out;

      if ((accept && clamp_c) || (s2_valid && acc_sat_c))
        sat <= 1'b1;

      case (state)
        IDLE: begin
          if (valid)
            err <= 1'b1;
          if (start) begin
            state     <= RUN;
            nf_lat    <= (num_frames == '0) ? FRM_W'(1) : num_frames;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            feeding   <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + FRM_W'(1);
              if (is_final)
                feeding <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + AW'(1);
            end
          end
          if (s2_valid && s2_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_integrator.sv
// tb_power_integrator
// Directed + randomized bench for power_integrator (LANES=4, DEPTH=8). Two
// instances share all inputs: dut_a with the default 53-bit accumulator and
// dut_b with a 43-bit accumulator so that accumulator saturation is reachable.
// A frame-level reference model (plain wide arithmetic over a per-address
// array) predicts every output beat, its cycle, done timing and sticky flags.
module tb_power_integrator;

  localparam int LANES = 4;
  localparam int IDW   = 32;
  localparam int DEPTH = 8;
  localparam int FRM_W = 8;
  localparam int OWA   = 53;
  localparam int OWB   = 43;
  localparam int AW    = 3;
  localparam logic [127:0] PMAX = (128'd1 << 43) - 128'd1;
  localparam logic [127:0] MAXA = (128'd1 << OWA) - 128'd1;
  localparam logic [127:0] MAXB = (128'd1 << OWB) - 128'd1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   valid = 1'b0;
  logic [FRM_W-1:0]       num_frames = '0;
  logic [LANES*IDW-1:0]   in_r = '0;
  logic [LANES*IDW-1:0]   in_i = '0;

  logic                   out_valid_a, busy_a, done_a, sat_a, err_a;
  logic [LANES*OWA-1:0]   out_data_a;
  logic [AW-1:0]          out_index_a;
  logic                   out_valid_b, busy_b, done_b, sat_b, err_b;
  logic [LANES*OWB-1:0]   out_data_b;
  logic [AW-1:0]          out_index_b;

  power_integrator #(.LANES(LANES), .IN_DATA_WIDTH(IDW), .LSB_CUTOFF(10),
                     .MSB_CUTOFF(52), .OUT_DATA_WIDTH(OWA), .DEPTH(DEPTH),
                     .FRM_W(FRM_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .valid(valid), .in_r(in_r), .in_i(in_i), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_index(out_index_a), .busy(busy_a),
    .done(done_a), .sat(sat_a), .err(err_a));

  power_integrator #(.LANES(LANES), .IN_DATA_WIDTH(IDW), .LSB_CUTOFF(10),
                     .MSB_CUTOFF(52), .OUT_DATA_WIDTH(OWB), .DEPTH(DEPTH),
                     .FRM_W(FRM_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .valid(valid), .in_r(in_r), .in_i(in_i), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_index(out_index_b), .busy(busy_b),
    .done(done_b), .sat(sat_b), .err(err_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  typedef struct {
    logic [LANES*OWA-1:0] da;
    logic [LANES*OWB-1:0] db;
    logic [AW-1:0]        idx;
    int                   cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] acc_a [DEPTH][LANES];
  logic [127:0] acc_b [DEPTH][LANES];
  int           m_beat = 0, m_frame = 0, m_nf = 1;
  bit           m_active = 0, m_sat_a = 0, m_sat_b = 0, m_err = 0;
  int           done_cyc = -1;
  bit           mon_en = 0;

  task automatic check_output(input string tag, input logic [255:0] obs,
                              input logic [255:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model for one accepted beat: exact power, half-up rounding,
  // clamp, then per-address integration with saturation at the output width.
  task automatic model_beat(input logic [LANES*IDW-1:0] r,
                            input logic [LANES*IDW-1:0] i);
    exp_t e;
    if (!m_active) begin
      m_err = 1;
      return;
    end
    for (int k = 0; k < LANES; k++) begin
      logic signed [IDW-1:0] rl, il;
      logic signed [127:0]   rx, ix;
      logic [127:0]          p, q;
      rl = r[k*IDW +: IDW];
      il = i[k*IDW +: IDW];
      rx = rl;
      ix = il;
      p  = rx * rx + ix * ix;
      q  = (p + 128'd512) >> 10;
      if (q > PMAX) begin
        q = PMAX;
        m_sat_a = 1;
        m_sat_b = 1;
      end
      if (m_frame == 0) begin
        acc_a[m_beat][k] = q;
        acc_b[m_beat][k] = q;
      end else begin
        acc_a[m_beat][k] = acc_a[m_beat][k] + q;
        acc_b[m_beat][k] = acc_b[m_beat][k] + q;
      end
      if (acc_a[m_beat][k] > MAXA) begin
        acc_a[m_beat][k] = MAXA;
        m_sat_a = 1;
      end
      if (acc_b[m_beat][k] > MAXB) begin
        acc_b[m_beat][k] = MAXB;
        m_sat_b = 1;
      end
      e.da[k*OWA +: OWA] = acc_a[m_beat][k][OWA-1:0];
      e.db[k*OWB +: OWB] = acc_b[m_beat][k][OWB-1:0];
    end
    if (m_frame == m_nf - 1) begin
      e.idx = AW'(m_beat);
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    m_beat++;
    if (m_beat == DEPTH) begin
      m_beat = 0;
      m_frame++;
      if (m_frame == m_nf) begin
        m_active = 0;
        done_cyc = cyc + 4;
      end
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [LANES*IDW-1:0] r,
                                input logic [LANES*IDW-1:0] i);
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = v;
    in_r  = r;
    in_i  = i;
    if (v) model_beat(r, i);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, '0, '0);
  endtask

  function automatic logic [LANES*IDW-1:0] rand_vec();
    logic [LANES*IDW-1:0] rv;
    for (int k = 0; k < LANES; k++) begin
      logic signed [IDW-1:0] v;
      v = $urandom;
      v = v >>> $urandom_range(0, 24);
      rv[k*IDW +: IDW] = v;
    end
    return rv;
  endfunction

  task automatic start_run(input int nf);
    @(posedge clk);
    #1;
    valid      = 1'b0;
    start      = 1'b1;
    num_frames = FRM_W'(nf);
    if (!m_active) begin
      m_active = 1;
      m_nf     = (nf == 0) ? 1 : nf;
      m_beat   = 0;
      m_frame  = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("busy_run", busy_a, 1'b1);
  endtask

  // gap: 0 back-to-back, 1 strict 1/0 toggling, 2 random gaps
  task automatic send_beats(input int n, input bit rnd,
                            input logic [LANES*IDW-1:0] r,
                            input logic [LANES*IDW-1:0] i, input int gap);
    logic [LANES*IDW-1:0] r2, i2;
    for (int b = 0; b < n; b++) begin
      r2 = rnd ? rand_vec() : r;
      i2 = rnd ? rand_vec() : i;
      apply_stimulus(1'b1, r2, i2);
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))
        apply_stimulus(1'b0, r2, i2);
    end
  endtask

  task automatic check_flags(input string tag);
    check_output({tag, "_busy"}, busy_a, 1'b0);
    check_output({tag, "_sat_a"}, sat_a, m_sat_a);
    check_output({tag, "_sat_b"}, sat_b, m_sat_b);
    check_output({tag, "_err_a"}, err_a, m_err);
    check_output({tag, "_err_b"}, err_b, m_err);
    check_output({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_test(input string tag, input int nf, input bit rnd,
                          input logic [LANES*IDW-1:0] r,
                          input logic [LANES*IDW-1:0] i, input int gap);
    start_run(nf);
    send_beats(((nf == 0) ? 1 : nf) * DEPTH, rnd, r, i, gap);
    idle(8);
    check_flags(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    valid = 1'b0;
    start = 1'b0;
    #1;
    check_output("rst_out_valid", {out_valid_b, out_valid_a}, 2'b00);
    check_output("rst_out_data_a", out_data_a, '0);
    check_output("rst_out_index_a", out_index_a, '0);
    check_output("rst_flags_a", {busy_a, done_a, sat_a, err_a}, 4'b0000);
    check_output("rst_flags_b", {busy_b, done_b, sat_b, err_b}, 4'b0000);
    exp_q.delete();
    done_cyc = -1;
    m_active = 0;
    m_sat_a  = 0;
    m_sat_b  = 0;
    m_err    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle-exact output monitor: every cycle, out_valid and done must match
  // the model's schedule, and expected beats are compared when they fall due.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check_output("out_valid_a", out_valid_a, ev);
      check_output("out_valid_b", out_valid_b, ev);
      if (ev) begin
        check_output("out_index_a", out_index_a, exp_q[0].idx);
        check_output("out_index_b", out_index_b, exp_q[0].idx);
        check_output("out_data_a", out_data_a, exp_q[0].da);
        check_output("out_data_b", out_data_b, exp_q[0].db);
        void'(exp_q.pop_front());
      end
      check_output("done_a", done_a, cyc == done_cyc);
      check_output("done_b", done_b, cyc == done_cyc);
    end
  end

  initial begin
    logic [LANES*IDW-1:0] r_const, i_zero, r_round, r_min;
    i_zero  = '0;
    r_const = {4{32'sd1024}};
    r_round = {-32'sd32, 32'sd32, 32'sd23, 32'sd22};
    r_min   = {4{32'h8000_0000}};

    repeat (3) @(posedge clk);
    #1;
    check_output("init_out_valid", {out_valid_b, out_valid_a}, 2'b00);
    check_output("init_out_data_a", out_data_a, '0);
    check_output("init_out_index_a", out_index_a, '0);
    check_output("init_flags_a", {busy_a, done_a, sat_a, err_a}, 4'b0000);
    check_output("init_flags_b", {busy_b, done_b, sat_b, err_b}, 4'b0000);
    rst = 1'b0;
    mon_en = 1;
    idle(2);

    $display("[TB] accumulation, 3 frames back-to-back");
    run_test("accum", 3, 0, r_const, i_zero, 0);

    $display("[TB] rounding, single frame");
    run_test("round", 1, 0, r_round, i_zero, 0);

    $display("[TB] random data, 2 frames, random gaps");
    run_test("rand2", 2, 1, '0, '0, 2);

    $display("[TB] accumulation with 1/0 valid toggling");
    run_test("toggle", 3, 0, r_const, i_zero, 1);

    $display("[TB] valid while idle");
    send_beats(3, 1, '0, '0, 0);
    idle(8);
    check_flags("idle_valid");

    do_reset();
    $display("[TB] start during run is ignored");
    start_run(2);
    send_beats(5, 1, '0, '0, 0);
    start_run(7);
    send_beats(11, 1, '0, '0, 0);
    idle(8);
    check_flags("restart");

    $display("[TB] num_frames 0 pass-through");
    run_test("nf0", 0, 1, '0, '0, 2);

    do_reset();
    $display("[TB] reset mid-frame then fresh 2-frame run");
    start_run(3);
    send_beats(DEPTH + 5, 1, '0, '0, 0);
    do_reset();
    run_test("after_rst", 2, 1, '0, '0, 0);

    do_reset();
    $display("[TB] power clamp");
    run_test("clamp", 1, 0, r_min, r_min, 0);

    do_reset();
    $display("[TB] long integration, 255 frames of full-scale input");
    run_test("accsat", 255, 0, r_min, r_min, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
